avg_ram_ctrl: RTL and testbench

- Parametrised control block for the FIFO → averager → RAM path.
- Pops bytes from the input FIFO whenever it is non-empty, steers the averager through a configurable number of bytes per word, and writes each completed word to RAM at an auto-incrementing address.
- Extends the fixed four-byte controller to any word length and RAM depth, and adds end-of-RAM handling.

---
 rtl/avg_ram_ctrl_pkg.sv | 16 +
 rtl/avg_ram_ctrl_if.sv | 39 +++
 rtl/ctrl_addr_cnt.sv | 70 +++++++
 rtl/avg_ram_ctrl.sv | 141 ++++++++++++++
 tb/tb_avg_ram_ctrl.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/avg_ram_ctrl_pkg.sv
// rtl/avg_ram_ctrl_pkg.sv - shared types and default constants for the FIFO-averager-RAM controller
package avg_ram_ctrl_pkg;

    // Controller states; the explicit encoding keeps the state register width fixed.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        LOAD  = 3'd2,
        WRITE = 3'd3,
        HALT  = 3'd4
    } state_t;

    localparam int DEF_BYTES_PER_WORD = 4;
    localparam int DEF_RAM_DEPTH      = 512;

endpackage

// File: rtl/avg_ram_ctrl_if.sv
// rtl/avg_ram_ctrl_if.sv - FIFO/averager/RAM control bundle with controller and environment modports
//
// Signals:
//   empty_flag  FIFO empty (environment -> controller)
//   rd_fifo     one-cycle FIFO pop strobe
//   zero_sel    averager starts a new word (zero + byte)
//   acc_en      averager captures FIFO data
//   byte_idx    index of the byte being loaded
//   wr_ram      one-cycle RAM write strobe
//   ram_addr    RAM write address
//   ram_full    RAM filled and controller halted
interface avg_ram_ctrl_if
    import avg_ram_ctrl_pkg::*;
#(
    parameter int BYTES_PER_WORD = DEF_BYTES_PER_WORD,
    parameter int RAM_DEPTH      = DEF_RAM_DEPTH,
    parameter int ADDR_W         = $clog2(RAM_DEPTH)
) ();

    logic                              empty_flag;
    logic                              rd_fifo;
    logic                              zero_sel;
    logic                              acc_en;
    logic [$clog2(BYTES_PER_WORD)-1:0] byte_idx;
    logic                              wr_ram;
    logic [ADDR_W-1:0]                 ram_addr;
    logic                              ram_full;

    modport master (
        input  empty_flag,
        output rd_fifo, zero_sel, acc_en, byte_idx, wr_ram, ram_addr, ram_full
    );

    modport slave (
        output empty_flag,
        input  rd_fifo, zero_sel, acc_en, byte_idx, wr_ram, ram_addr, ram_full
    );

endinterface

// File: rtl/ctrl_addr_cnt.sv
// rtl/ctrl_addr_cnt.sv - byte index and RAM address counters for the averager controller
//
// Ports:
//   clk_i, resetn_i      clock and synchronous active-low reset
//   byte_inc_i/clr_i     advance / restart the byte index
//   addr_inc_i/wrap_i    advance / return-to-zero the RAM address
//   byte_idx_o           current byte index
//   ram_addr_o           current RAM address
//   last_byte_o          byte index is at the final byte of a word
//   last_addr_o          RAM address is at the final word
module ctrl_addr_cnt
    import avg_ram_ctrl_pkg::*;
#(
    parameter int BYTES_PER_WORD = DEF_BYTES_PER_WORD,
    parameter int RAM_DEPTH      = DEF_RAM_DEPTH,
    parameter int ADDR_W         = $clog2(RAM_DEPTH),
    parameter int BIDX_W         = $clog2(BYTES_PER_WORD)
) (
    input  logic              clk_i,
    input  logic              resetn_i,
    input  logic              byte_inc_i,
    input  logic              byte_clr_i,
    input  logic              addr_inc_i,
    input  logic              addr_wrap_i,
    output logic [BIDX_W-1:0] byte_idx_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic              last_byte_o,
    output logic              last_addr_o
);

    localparam logic [BIDX_W-1:0] LAST_BYTE = BIDX_W'(BYTES_PER_WORD - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RAM_DEPTH - 1);

    logic [BIDX_W-1:0] byte_idx_q, byte_idx_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;

    always_comb begin
        byte_idx_d = byte_idx_q;
        if (byte_clr_i) begin
            byte_idx_d = '0;
        end else if (byte_inc_i) begin
            byte_idx_d = byte_idx_q + BIDX_W'(1);
        end
    end

    always_comb begin
        ram_addr_d = ram_addr_q;
        if (addr_wrap_i) begin
            ram_addr_d = '0;
        end else if (addr_inc_i) begin
            ram_addr_d = ram_addr_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            byte_idx_q <= '0;
            ram_addr_q <= '0;
        end else begin
            byte_idx_q <= byte_idx_d;
            ram_addr_q <= ram_addr_d;
        end
    end

    assign byte_idx_o  = byte_idx_q;
    assign ram_addr_o  = ram_addr_q;
    assign last_byte_o = (byte_idx_q == LAST_BYTE);
    assign last_addr_o = (ram_addr_q == LAST_ADDR);

endmodule

// File: rtl/avg_ram_ctrl.sv
// rtl/avg_ram_ctrl.sv - FIFO -> averager -> RAM controller with configurable word length and RAM depth
//
// Ports:
//   clk_2     sole clock, rising edge
//   reset_n   synchronous active-low reset
//   bus       avg_ram_ctrl_if.master: empty_flag in; rd_fifo, zero_sel, acc_en,
//             byte_idx, wr_ram, ram_addr, ram_full out
//
// Build option AVG_RAM_CTRL_WRAP_EN: when defined the RAM address wraps to 0
// after the last word; when undefined the controller halts with ram_full=1.
module avg_ram_ctrl
    import avg_ram_ctrl_pkg::*;
#(
    parameter int BYTES_PER_WORD = DEF_BYTES_PER_WORD,
    parameter int RAM_DEPTH      = DEF_RAM_DEPTH,
    parameter int ADDR_W         = $clog2(RAM_DEPTH)
) (
    input  logic             clk_2,
    input  logic             reset_n,
    avg_ram_ctrl_if.master   bus
);

    localparam int BIDX_W = $clog2(BYTES_PER_WORD);

    state_t            state_q;
    logic              rd_fifo_q;
    logic              acc_en_q;
    logic              zero_sel_q;
    logic              wr_ram_q;
    logic [BIDX_W-1:0] byte_idx;
    logic [ADDR_W-1:0] ram_addr;
    logic              last_byte;
    logic              last_addr;
    logic              in_load;
    logic              in_write;
    logic              addr_wrap;

    assign in_load  = (state_q == LOAD);
    assign in_write = (state_q == WRITE);

`ifdef AVG_RAM_CTRL_WRAP_EN
    assign addr_wrap = in_write && last_addr;
`else
    assign addr_wrap = 1'b0;
`endif

    ctrl_addr_cnt #(
        .BYTES_PER_WORD (BYTES_PER_WORD),
        .RAM_DEPTH      (RAM_DEPTH),
        .ADDR_W         (ADDR_W),
        .BIDX_W         (BIDX_W)
    ) u_cnt (
        .clk_i       (clk_2),
        .resetn_i    (reset_n),
        .byte_inc_i  (in_load && !last_byte),
        .byte_clr_i  (in_load && last_byte),
        .addr_inc_i  (in_write && !last_addr),
        .addr_wrap_i (addr_wrap),
        .byte_idx_o  (byte_idx),
        .ram_addr_o  (ram_addr),
        .last_byte_o (last_byte),
        .last_addr_o (last_addr)
    );

`ifndef AVG_RAM_CTRL_WRAP_EN
    logic ram_full_q;
`endif

    // Strobes are registered alongside the state transition so each one is
    // high exactly while the FSM sits in the matching state.
    always_ff @(posedge clk_2) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            rd_fifo_q  <= 1'b0;
            acc_en_q   <= 1'b0;
            zero_sel_q <= 1'b0;
            wr_ram_q   <= 1'b0;
`ifndef AVG_RAM_CTRL_WRAP_EN
            ram_full_q <= 1'b0;
`endif
        end else begin
            rd_fifo_q  <= 1'b0;
            acc_en_q   <= 1'b0;
            zero_sel_q <= 1'b0;
            wr_ram_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!bus.empty_flag) begin
                        state_q   <= READ;
                        rd_fifo_q <= 1'b1;
                    end
                end
                READ: begin
                    // byte_idx is stable through READ and LOAD, so it decides zero_sel here.
                    state_q    <= LOAD;
                    acc_en_q   <= 1'b1;
                    zero_sel_q <= (byte_idx == '0);
                end
                LOAD: begin
                    if (last_byte) begin
                        state_q  <= WRITE;
                        wr_ram_q <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                WRITE: begin
`ifdef AVG_RAM_CTRL_WRAP_EN
                    state_q <= IDLE;
`else
                    if (last_addr) begin
                        state_q    <= HALT;
                        ram_full_q <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                    end
`endif
                end
                HALT: begin
                    state_q <= HALT;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.rd_fifo  = rd_fifo_q;
    assign bus.acc_en   = acc_en_q;
    assign bus.zero_sel = zero_sel_q;
    assign bus.wr_ram   = wr_ram_q;
    assign bus.byte_idx = byte_idx;
    assign bus.ram_addr = ram_addr;
`ifdef AVG_RAM_CTRL_WRAP_EN
    assign bus.ram_full = 1'b0;
`else
    assign bus.ram_full = ram_full_q;
`endif

endmodule

// File: tb/tb_avg_ram_ctrl.sv
// tb/tb_avg_ram_ctrl.sv - self-checking bench for avg_ram_ctrl, two parameter sets against a byte/word count model
module tb_avg_ram_ctrl;

`ifdef AVG_RAM_CTRL_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic clk_2 = 1'b0;
    logic reset_n;
    logic empty_flag;

    always #5 clk_2 = ~clk_2;

    avg_ram_ctrl_if #(.BYTES_PER_WORD(4), .RAM_DEPTH(4)) bus_a ();
    avg_ram_ctrl_if #(.BYTES_PER_WORD(3), .RAM_DEPTH(8)) bus_b ();

    assign bus_a.empty_flag = empty_flag;
    assign bus_b.empty_flag = empty_flag;

    avg_ram_ctrl #(.BYTES_PER_WORD(4), .RAM_DEPTH(4)) dut_a (
        .clk_2   (clk_2),
        .reset_n (reset_n),
        .bus     (bus_a.master)
    );

    avg_ram_ctrl #(.BYTES_PER_WORD(3), .RAM_DEPTH(8)) dut_b (
        .clk_2   (clk_2),
        .reset_n (reset_n),
        .bus     (bus_b.master)
    );

    int checks = 0;
    int fails  = 0;

    // Reference: per DUT, a phase within the current byte transfer
    // (0 waiting, 1 pop, 2 capture, 3 write), plus running counts of bytes
    // captured and words written since the last reset.
    int phase [2];
    int bytes [2];
    int words [2];

    function automatic int bpw(input int k);
        return (k == 0) ? 4 : 3;
    endfunction

    function automatic int depth(input int k);
        return (k == 0) ? 4 : 8;
    endfunction

    function automatic bit is_full(input int k);
        return !WRAP && (words[k] >= depth(k));
    endfunction

    task automatic model_edge(input int k);
        if (!reset_n) begin
            phase[k] = 0;
            bytes[k] = 0;
            words[k] = 0;
        end else begin
            case (phase[k])
                0: if (!is_full(k) && !empty_flag) phase[k] = 1;
                1: phase[k] = 2;
                2: begin
                    bytes[k] = bytes[k] + 1;
                    phase[k] = (bytes[k] % bpw(k) == 0) ? 3 : 0;
                end
                default: begin
                    words[k] = words[k] + 1;
                    phase[k] = 0;
                end
            endcase
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_dut(input int k, input logic rd, input logic acc, input logic zs,
                             input logic wr, input logic [31:0] bidx, input logic [31:0] addr,
                             input logic full);
        string p;
        int exp_addr;
        p = (k == 0) ? "a." : "b.";
        exp_addr = is_full(k) ? depth(k) - 1 : words[k] % depth(k);
        check({p, "rd_fifo"},  {31'd0, rd},  32'(phase[k] == 1));
        check({p, "acc_en"},   {31'd0, acc}, 32'(phase[k] == 2));
        check({p, "zero_sel"}, {31'd0, zs},  32'(phase[k] == 2 && bytes[k] % bpw(k) == 0));
        check({p, "wr_ram"},   {31'd0, wr},  32'(phase[k] == 3));
        check({p, "byte_idx"}, bidx,         32'(bytes[k] % bpw(k)));
        check({p, "ram_addr"}, addr,         32'(exp_addr));
        check({p, "ram_full"}, {31'd0, full}, 32'(is_full(k)));
    endtask

    task automatic cycle();
        @(posedge clk_2);
        model_edge(0);
        model_edge(1);
        #1;
        check_dut(0, bus_a.rd_fifo, bus_a.acc_en, bus_a.zero_sel, bus_a.wr_ram,
                  32'(bus_a.byte_idx), 32'(bus_a.ram_addr), bus_a.ram_full);
        check_dut(1, bus_b.rd_fifo, bus_b.acc_en, bus_b.zero_sel, bus_b.wr_ram,
                  32'(bus_b.byte_idx), 32'(bus_b.ram_addr), bus_b.ram_full);
    endtask

    task automatic run(input int n, input logic empty);
        empty_flag = empty;
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            phase[k] = 0;
            bytes[k] = 0;
            words[k] = 0;
        end

        // Reset with FIFO non-empty: all outputs held at zero.
        reset_n    = 1'b0;
        empty_flag = 1'b0;
        cycle();
        cycle();
        reset_n = 1'b1;

        // Continuous data: steady byte cadence and first word writes.
        run(30, 1'b0);

        // FIFO goes empty for 5 cycles mid-word, then resumes.
        run(5, 1'b1);
        run(12, 1'b0);

        // Reset pulse part-way through a word.
        reset_n = 1'b0;
        cycle();
        reset_n = 1'b1;
        run(8, 1'b0);
        reset_n = 1'b0;
        cycle();
        reset_n = 1'b1;

        // Keep the FIFO non-empty long enough to fill both RAMs and idle well beyond.
        run(130, 1'b0);

        // Reset must clear ram_full and restart at address 0.
        reset_n = 1'b0;
        cycle();
        reset_n = 1'b1;
        run(10, 1'b0);

        // Random FIFO occupancy with occasional resets.
        for (int i = 0; i < 400; i++) begin
            empty_flag = ($urandom_range(0, 2) == 0);
            reset_n    = ($urandom_range(0, 79) != 0);
            cycle();
        end
        reset_n = 1'b1;
        run(150, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
